// File: rtl/dep_check_unit.sv
// Operand-dependency tracker for the in-order pipeline: produces forwarding selects,
// inserts a single bubble on load-use hazards and registers the EX/DM-stage controls.

module dep_hit #(
  parameter int REG_AW = 5
) (
  input  logic              valid,
  input  logic              writes,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] src,
  output logic              hit
);
  // r0 is hard-wired zero, so it never names a producer
  assign hit = valid & writes & (rd == src) & (src != '0);
endmodule

module dep_check_unit #(
  parameter int         REG_AW    = 5,
  parameter int         FWD_DEPTH = 3,
  parameter logic [5:0] OP_LOAD   = 6'b100011,
  parameter logic [5:0] OP_STORE  = 6'b101011,
  localparam int        SEL_W     = $clog2(FWD_DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_valid,
  input  logic [31:0]       ins,
  output logic              stall,
  output logic              ex_valid,
  output logic [5:0]        op_ex,
  output logic [15:0]       imm_ex,
  output logic [REG_AW-1:0] rw_ex,
  output logic [SEL_W-1:0]  mux_sel_A,
  output logic [SEL_W-1:0]  mux_sel_B,
  output logic              imm_sel,
  output logic              mem_en_ex,
  output logic              mem_rw_ex,
  output logic [REG_AW-1:0] RW_dm,
  output logic              mem_mux_sel_dm,
  output logic              wb_valid_dm
);

  typedef struct packed {
    logic              valid;
    logic              writes;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } hist_t;

  logic [5:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [15:0]       imm;
  logic              is_load, is_store, imm_sel_d, writes, reads_b, issue;
  hist_t             dec;
  hist_t             h [FWD_DEPTH];
  logic [FWD_DEPTH-1:0] hit_a, hit_b;
  logic [SEL_W-1:0]  sel_a, sel_b;

  assign op        = ins[31:26];
  assign rd        = REG_AW'(ins[25:21]);
  assign rs1       = REG_AW'(ins[20:16]);
  assign rs2       = REG_AW'(ins[15:11]);
  assign imm       = ins[15:0];
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign imm_sel_d = (op[5:3] == 3'b001) | is_load | is_store;
  assign writes    = ~is_store;
  // stores still read rs2 as the data operand even though the ALU takes imm
  assign reads_b   = ~imm_sel_d | is_store;

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.writes  = writes;
    dec.rd      = rd;
    dec.is_load = is_load;
  end

  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_hit
    dep_hit #(.REG_AW(REG_AW)) u_hit_a (
      .valid(h[k].valid), .writes(h[k].writes), .rd(h[k].rd), .src(rs1), .hit(hit_a[k])
    );
    dep_hit #(.REG_AW(REG_AW)) u_hit_b (
      .valid(h[k].valid), .writes(h[k].writes), .rd(h[k].rd), .src(rs2), .hit(hit_b[k])
    );
  end

  // scan oldest to youngest so the nearest producer overrides
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = FWD_DEPTH-1; k >= 0; k--) begin
      if (hit_a[k])           sel_a = SEL_W'(k+1);
      if (hit_b[k] & reads_b) sel_b = SEL_W'(k+1);
    end
  end

  // a load in EX has no result yet; hold decode one cycle until it reaches DM
  assign stall = ~reset & ins_valid & h[0].valid & h[0].is_load & (h[0].rd != '0) &
                 ((rs1 == h[0].rd) | (reads_b & (rs2 == h[0].rd)));
  assign issue = ins_valid & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < FWD_DEPTH; k++) h[k] <= '0;
      ex_valid       <= 1'b0;
      op_ex          <= '0;
      imm_ex         <= '0;
      rw_ex          <= '0;
      mux_sel_A      <= '0;
      mux_sel_B      <= '0;
      imm_sel        <= 1'b0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      RW_dm          <= '0;
      mem_mux_sel_dm <= 1'b0;
      wb_valid_dm    <= 1'b0;
    end else begin
      for (int k = 1; k < FWD_DEPTH; k++) h[k] <= h[k-1];
      if (issue) begin
        h[0]      <= dec;
        ex_valid  <= 1'b1;
        op_ex     <= op;
        imm_ex    <= imm;
        rw_ex     <= rd;
        mux_sel_A <= sel_a;
        mux_sel_B <= sel_b;
        imm_sel   <= imm_sel_d;
        mem_en_ex <= is_load | is_store;
        mem_rw_ex <= is_store;
      end else begin
        h[0]      <= '0;
        ex_valid  <= 1'b0;
        op_ex     <= '0;
        imm_ex    <= '0;
        rw_ex     <= '0;
        mux_sel_A <= '0;
        mux_sel_B <= '0;
        imm_sel   <= 1'b0;
        mem_en_ex <= 1'b0;
        mem_rw_ex <= 1'b0;
      end
      RW_dm          <= h[1].rd;
      mem_mux_sel_dm <= h[1].valid & h[1].is_load;
      wb_valid_dm    <= h[1].valid & h[1].writes;
    end
  end

endmodule

// File: tb/tb_dep_check_unit.sv
// Directed vector bench for dep_check_unit; a depth-3 and a depth-4 instance see
// the same stimulus and differ only in how far back forwarding reaches.

module tb_dep_check_unit;

  localparam logic [5:0] LD = 6'b100011;
  localparam logic [5:0] ST = 6'b101011;

  logic        clk = 1'b0;
  logic        reset;
  logic        ins_valid;
  logic [31:0] ins;

  logic        stall3, ev3, isel3, men3, mrw3, mmx3, wbv3;
  logic [5:0]  op3;
  logic [15:0] imm3;
  logic [4:0]  rw3, rwdm3;
  logic [1:0]  sa3, sb3;

  logic        stall4, ev4, isel4, men4, mrw4, mmx4, wbv4;
  logic [5:0]  op4;
  logic [15:0] imm4;
  logic [4:0]  rw4, rwdm4;
  logic [2:0]  sa4, sb4;

  always #5 clk = ~clk;

  dep_check_unit #(.FWD_DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins(ins), .stall(stall3),
    .ex_valid(ev3), .op_ex(op3), .imm_ex(imm3), .rw_ex(rw3), .mux_sel_A(sa3),
    .mux_sel_B(sb3), .imm_sel(isel3), .mem_en_ex(men3), .mem_rw_ex(mrw3),
    .RW_dm(rwdm3), .mem_mux_sel_dm(mmx3), .wb_valid_dm(wbv3)
  );

  dep_check_unit #(.FWD_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins(ins), .stall(stall4),
    .ex_valid(ev4), .op_ex(op4), .imm_ex(imm4), .rw_ex(rw4), .mux_sel_A(sa4),
    .mux_sel_B(sb4), .imm_sel(isel4), .mem_en_ex(men4), .mem_rw_ex(mrw4),
    .RW_dm(rwdm4), .mem_mux_sel_dm(mmx4), .wb_valid_dm(wbv4)
  );

  typedef struct {
    logic        vld;
    logic [31:0] ins;
    logic        stall;
    logic        ev;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [4:0]  rw;
    logic [2:0]  sa, sb, sa4, sb4;
    logic        isel, men, mrw;
    logic [4:0]  rwdm;
    logic        mmx, wbv;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [31:0] rt(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'b0};
  endfunction

  function automatic logic [31:0] it(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1, logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic add(logic vld, logic [31:0] i, logic st, logic ev, logic [5:0] op, logic [15:0] imm,
                     logic [4:0] rw, logic [2:0] sa, logic [2:0] sb, logic [2:0] sa4, logic [2:0] sb4,
                     logic isel, logic men, logic mrw, logic [4:0] rwdm, logic mmx, logic wbv);
    vec_t v;
    v.vld = vld; v.ins = i; v.stall = st; v.ev = ev; v.op = op; v.imm = imm; v.rw = rw;
    v.sa = sa; v.sb = sb; v.sa4 = sa4; v.sb4 = sb4; v.isel = isel; v.men = men; v.mrw = mrw;
    v.rwdm = rwdm; v.mmx = mmx; v.wbv = wbv;
    vecs.push_back(v);
  endtask

  // idle cycle: EX side is a bubble, only the DM side carries information
  task automatic addx(logic [4:0] rwdm, logic mmx, logic wbv);
    add(1'b0, 32'h0, 0, 0, 6'h0, 16'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0, rwdm, mmx, wbv);
  endtask

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
  endtask

  task automatic chk_regs(int idx, vec_t e);
    chk("ex_valid", idx, 32'(ev3), 32'(e.ev));   chk("ex_valid4", idx, 32'(ev4), 32'(e.ev));
    chk("op_ex", idx, 32'(op3), 32'(e.op));      chk("op_ex4", idx, 32'(op4), 32'(e.op));
    chk("imm_ex", idx, 32'(imm3), 32'(e.imm));   chk("imm_ex4", idx, 32'(imm4), 32'(e.imm));
    chk("rw_ex", idx, 32'(rw3), 32'(e.rw));      chk("rw_ex4", idx, 32'(rw4), 32'(e.rw));
    chk("sel_A", idx, 32'(sa3), 32'(e.sa));      chk("sel_A4", idx, 32'(sa4), 32'(e.sa4));
    chk("sel_B", idx, 32'(sb3), 32'(e.sb));      chk("sel_B4", idx, 32'(sb4), 32'(e.sb4));
    chk("imm_sel", idx, 32'(isel3), 32'(e.isel)); chk("imm_sel4", idx, 32'(isel4), 32'(e.isel));
    chk("mem_en", idx, 32'(men3), 32'(e.men));   chk("mem_en4", idx, 32'(men4), 32'(e.men));
    chk("mem_rw", idx, 32'(mrw3), 32'(e.mrw));   chk("mem_rw4", idx, 32'(mrw4), 32'(e.mrw));
    chk("RW_dm", idx, 32'(rwdm3), 32'(e.rwdm));  chk("RW_dm4", idx, 32'(rwdm4), 32'(e.rwdm));
    chk("mem_mux_dm", idx, 32'(mmx3), 32'(e.mmx)); chk("mem_mux_dm4", idx, 32'(mmx4), 32'(e.mmx));
    chk("wb_valid_dm", idx, 32'(wbv3), 32'(e.wbv)); chk("wb_valid_dm4", idx, 32'(wbv4), 32'(e.wbv));
  endtask

  initial begin
    vec_t z;
    // vld ins                       st ev op     imm       rw  sA sB A4 B4 is me mr  rwdm mmx wbv
    add(1, rt(6'h0, 3, 1, 2),        0, 1, 6'h00, 16'h1000, 3,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(1, rt(6'h0, 4, 3, 3),        0, 1, 6'h00, 16'h1800, 4,  1, 1, 1, 1, 0, 0, 0,  0, 0, 0);
    addx(3, 0, 1);
    add(1, rt(6'h0, 3, 0, 0),        0, 1, 6'h00, 16'h0,    3,  0, 0, 0, 0, 0, 0, 0,  4, 0, 1);
    addx(0, 0, 0);
    add(1, rt(6'h0, 8, 3, 0),        0, 1, 6'h00, 16'h0,    8,  2, 0, 2, 0, 0, 0, 0,  3, 0, 1);
    add(1, rt(6'h0, 3, 0, 0),        0, 1, 6'h00, 16'h0,    3,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    addx(8, 0, 1);
    addx(3, 0, 1);
    add(1, rt(6'h0, 9, 3, 0),        0, 1, 6'h00, 16'h0,    9,  3, 0, 3, 0, 0, 0, 0,  0, 0, 0);
    add(1, rt(6'h0, 3, 0, 0),        0, 1, 6'h00, 16'h0,    3,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    addx(9, 0, 1);
    addx(3, 0, 1);
    addx(0, 0, 0);
    add(1, rt(6'h0, 10, 3, 0),       0, 1, 6'h00, 16'h0,    10, 0, 0, 4, 0, 0, 0, 0,  0, 0, 0);
    add(1, it(LD, 5, 1, 16'h4),      0, 1, 6'h23, 16'h4,    5,  0, 0, 0, 0, 1, 1, 0,  0, 0, 0);
    add(1, rt(6'h0, 6, 5, 0),        1, 0, 6'h00, 16'h0,    0,  0, 0, 0, 0, 0, 0, 0, 10, 0, 1);
    add(1, rt(6'h0, 6, 5, 0),        0, 1, 6'h00, 16'h0,    6,  2, 0, 2, 0, 0, 0, 0,  5, 1, 1);
    add(1, rt(6'h0, 7, 0, 0),        0, 1, 6'h00, 16'h0,    7,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(1, rt(6'h0, 7, 0, 0),        0, 1, 6'h00, 16'h0,    7,  0, 0, 0, 0, 0, 0, 0,  6, 0, 1);
    add(1, rt(6'h0, 11, 7, 7),       0, 1, 6'h00, 16'h3800, 11, 1, 1, 1, 1, 0, 0, 0,  7, 0, 1);
    add(1, it(6'h0D, 6, 1, 16'h3005),0, 1, 6'h0D, 16'h3005, 6,  0, 0, 0, 0, 1, 0, 0,  7, 0, 1);
    add(1, it(ST, 2, 1, 16'h3008),   0, 1, 6'h2B, 16'h3008, 2,  0, 1, 0, 1, 1, 1, 1, 11, 0, 1);
    add(1, rt(6'h0, 12, 2, 0),       0, 1, 6'h00, 16'h0,    12, 0, 0, 0, 0, 0, 0, 0,  6, 0, 1);
    addx(2, 0, 0);
    add(1, rt(6'h0, 0, 0, 0),        0, 1, 6'h00, 16'h0,    0,  0, 0, 0, 0, 0, 0, 0, 12, 0, 1);
    add(1, it(LD, 0, 0, 16'h0),      0, 1, 6'h23, 16'h0,    0,  0, 0, 0, 0, 1, 1, 0,  0, 0, 0);
    add(1, rt(6'h0, 13, 0, 0),       0, 1, 6'h00, 16'h0,    13, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1);

    // reset with a load presented: no stall, everything cleared
    reset = 1'b1; ins_valid = 1'b1; ins = it(LD, 5, 1, 16'h4);
    z = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    chk("stall_rst", -1, 32'(stall3), 32'd0);
    chk("stall_rst4", -1, 32'(stall4), 32'd0);
    chk_regs(-1, z);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ins_valid = vecs[i].vld;
      ins       = vecs[i].ins;
      #2;
      chk("stall", i, 32'(stall3), 32'(vecs[i].stall));
      chk("stall4", i, 32'(stall4), 32'(vecs[i].stall));
      @(posedge clk);
      #1;
      chk_regs(i, vecs[i]);
    end

    // reset lands while a load-use stall is being held
    ins_valid = 1'b1; ins = it(LD, 5, 1, 16'h4);
    @(posedge clk); #1;
    ins = rt(6'h0, 6, 5, 0);
    #1;
    chk("stall_pre", 100, 32'(stall3), 32'd1);
    reset = 1'b1;
    #1;
    chk("stall_gated", 101, 32'(stall3), 32'd0);
    chk("stall_gated4", 101, 32'(stall4), 32'd0);
    @(posedge clk); #1;
    chk_regs(102, z);
    reset = 1'b0;
    #1;
    chk("stall_post", 103, 32'(stall3), 32'd0);
    chk("stall_post4", 103, 32'(stall4), 32'd0);
    @(posedge clk); #1;
    chk("reissue_ev", 104, 32'(ev3), 32'd1);
    chk("reissue_rw", 104, 32'(rw3), 32'd6);
    chk("reissue_selA", 104, 32'(sa3), 32'd0);
    chk("reissue_selA4", 104, 32'(sa4), 32'd0);
    chk("reissue_wb_dm", 104, 32'(wbv3), 32'd0);
    ins_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dep_check_unit.md
Name: dep_check_unit

Overview:
- Parametrised operand-dependency and forwarding unit for the in-order MIPS-style pipeline; successor to the fixed 3-stage dependency checker.
- Sits between decode and the ID/EX register. Tracks the destinations of the last FWD_DEPTH in-flight instructions and registers the EX-stage controls: forwarding selects, imm select and memory controls.
- Adds two things the fixed block lacks: a configurable forwarding depth and load-use stall/bubble insertion.

Parameters:
- REG_AW, 5: register address width.
- FWD_DEPTH, 3: tracked in-flight stages (legal 2..4). Entry h[0]=EX, h[1]=DM, h[2]=WB, ...
- OP_LOAD, 6'b100011: load opcode.
- OP_STORE, 6'b101011: store opcode.
- SEL_W (localparam), $clog2(FWD_DEPTH+1): forwarding select width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- ins_valid  in  1  ins holds a valid instruction this cycle.
- ins  in  32  instruction fields: op[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0].
- stall  out  1  combinational; upstream must hold ins and ins_valid.
- ex_valid  out  1  EX-stage instruction valid (0 = bubble).
- op_ex  out  6  EX opcode.
- imm_ex  out  16  EX immediate.
- rw_ex  out  REG_AW  EX destination register.
- mux_sel_A  out  SEL_W  operand A source. 0 = register file; k = h[k-1] result.
- mux_sel_B  out  SEL_W  operand B / store-data source; same encoding as mux_sel_A.
- imm_sel  out  1  ALU operand B is imm_ex.
- mem_en_ex  out  1  EX instruction is a load or store.
- mem_rw_ex  out  1  1 = store, 0 = load.
- RW_dm  out  REG_AW  DM-stage destination.
- mem_mux_sel_dm  out  1  DM writeback takes memory data.
- wb_valid_dm  out  1  DM instruction will write RW_dm.

Behaviour:
- Synchronous, active-high reset, highest priority. Clears all history valid bits. Every registered output goes to 0. stall is gated to 0 while reset=1.
- Decode (combinational, on ins):
  - is_load = (op==OP_LOAD); is_store = (op==OP_STORE).
  - imm_sel_d = (op[5:3]==3'b001) | is_load | is_store.
  - writes = ~is_store.
  - reads_B = ~imm_sel_d | is_store.
- History entry h[k] holds {valid, writes, rd, is_load}.
- Forwarding A:
  - Match at k: h[k].valid & h[k].writes & h[k].rd==rs1 & rs1!=0.
  - sel_A = (smallest matching k)+1, else 0. The nearest producer wins.
- Forwarding B: same rule on rs2, evaluated only when reads_B. When ~reads_B, sel_B=0.
- stall = ~reset & ins_valid & h[0].valid & h[0].is_load & h[0].rd!=0 & (rs1==h[0].rd | (reads_B & rs2==h[0].rd)).
- Each clock edge (not reset):
  - History shifts: h[k+1]<=h[k]; h[FWD_DEPTH-1] drops out.
  - If ins_valid & ~stall:
    - h[0] <= decoded instruction.
    - EX outputs register op, imm, rd, sel_A, sel_B, imm_sel_d, mem_en=(is_load|is_store), mem_rw=is_store.
    - ex_valid<=1.
  - Else (stall or no instruction):
    - h[0] <= bubble (valid=0).
    - All EX outputs <= 0, including ex_valid.
- Latency: one cycle from ins to the EX outputs.
- Load-use: exactly one bubble per hazard. The next cycle the load sits in h[1], stall deasserts and the select becomes 2.
- DM outputs (registered, two cycles after issue):
  - RW_dm = h[1].rd.
  - mem_mux_sel_dm = h[1].valid & h[1].is_load.
  - wb_valid_dm = h[1].valid & h[1].writes.
- Register 0 never forwards and never causes a stall.
- Reset asserted mid-stall: the following cycle stall=0 and the pipeline is empty. The held instruction re-issues with no dependencies.

Test Plan:
- Reset, then ADD op=000000 rd=3 rs1=1 rs2=2, followed by op=000000 rd=4 rs1=3 rs2=3.
  - Cycle 1: op_ex=0, rw_ex=3, selects 0.
  - Cycle 2: mux_sel_A=1, mux_sel_B=1.
- Producer of r3, then one bubble, then a consumer of r3 → mux_sel_A=2. With one more bubble → mux_sel_A=3. A consumer issued after a further bubble → 0.
- LOAD op=OP_LOAD rd=5 rs1=1 imm=4, then op=000000 rd=6 rs1=5 rs2=0.
  - stall=1 for exactly one cycle; ex_valid=0 in the following cycle.
  - Then mux_sel_A=2, and mem_mux_sel_dm=1 with RW_dm=5 in the same cycle.
- Two producers of r7 back-to-back, then a consumer of r7 → mux_sel_A=1 (nearest wins).
- Imm op=001101 rd=6 rs1=1 imm=5 with rs2 field =6 → imm_sel=1, mux_sel_B=0. STORE rs2=6 after that producer → mem_en_ex=1, mem_rw_ex=1, mux_sel_B=1.
- Write to r0 then read r0 → selects 0, no stall. Reset asserted during a load-use stall → stall=0 next cycle, all outputs 0. Repeat with FWD_DEPTH=4 and three bubbles between producer and consumer → mux_sel_A=4.
